// File: rtl/reset_sequencer.sv
// Staged reset release sequencer: waits for a stable PLL lock, releases three
// active-low resets in order, then supervises downstream readiness with retries.
module reset_sequencer #(
    parameter int SYNC_STAGES          = 2,
    parameter int LOCK_STABLE_CYCLES   = 1000,
    parameter int STAGE_GAP_CYCLES     = 256,
    parameter int READY_TIMEOUT_CYCLES = 10_000_000,
    parameter int MAX_RETRIES          = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       ready_in,
    output logic [2:0] reset_out,
    output logic       all_ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_LOCK  = 3'd1,
        RELEASE    = 3'd2,
        WAIT_READY = 3'd3,
        RUN        = 3'd4,
        FAULT      = 3'd5
    } state_t;

    localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE_CYCLES - 1);
    localparam logic [31:0] GAP_LAST     = 32'(STAGE_GAP_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(READY_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  RETRY_LIMIT  = 2'(MAX_RETRIES);

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_sync;
    logic [31:0]            stable_cnt, stable_nxt;
    logic [31:0]            cycle_cnt, cycle_nxt;
    logic [2:0]             reset_out_nxt;
    logic                   all_ready_nxt;
    logic                   fault_nxt;
    logic [1:0]             retry_nxt;
    logic                   lose_lock;
    logic                   retry_req;

    assign locked_sync = sync_q[SYNC_STAGES-1];
    assign state_dbg   = state;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q      <= '0;
            state       <= IDLE;
            stable_cnt  <= '0;
            cycle_cnt   <= '0;
            reset_out   <= '0;
            all_ready   <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            state       <= state_nxt;
            stable_cnt  <= stable_nxt;
            cycle_cnt   <= cycle_nxt;
            reset_out   <= reset_out_nxt;
            all_ready   <= all_ready_nxt;
            fault       <= fault_nxt;
            retry_count <= retry_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        stable_nxt    = stable_cnt;
        cycle_nxt     = cycle_cnt;
        reset_out_nxt = reset_out;
        all_ready_nxt = all_ready;
        fault_nxt     = fault;
        retry_nxt     = retry_count;
        lose_lock     = 1'b0;
        retry_req     = 1'b0;

        case (state)
            IDLE: begin
                state_nxt     = WAIT_LOCK;
                reset_out_nxt = '0;
                all_ready_nxt = 1'b0;
                stable_nxt    = '0;
                cycle_nxt     = '0;
            end
            WAIT_LOCK: begin
                reset_out_nxt = '0;
                all_ready_nxt = 1'b0;
                if (!locked_sync) begin
                    stable_nxt = '0;
                end else if (stable_cnt == STABLE_LAST) begin
                    state_nxt     = RELEASE;
                    stable_nxt    = '0;
                    cycle_nxt     = '0;
                    reset_out_nxt = 3'b001;
                end else begin
                    stable_nxt = stable_cnt + 32'd1;
                end
            end
            RELEASE: begin
                if (!locked_sync) begin
                    lose_lock = 1'b1;
                end else if (cycle_cnt == GAP_LAST) begin
                    cycle_nxt = '0;
                    // Bit 1 already released means this gap ends with the last stage.
                    if (reset_out[1]) begin
                        reset_out_nxt = 3'b111;
                        state_nxt     = WAIT_READY;
                    end else begin
                        reset_out_nxt = 3'b011;
                    end
                end else begin
                    cycle_nxt = cycle_cnt + 32'd1;
                end
            end
            WAIT_READY: begin
                if (!locked_sync) begin
                    lose_lock = 1'b1;
                end else if (ready_in) begin
                    state_nxt     = RUN;
                    all_ready_nxt = 1'b1;
                    cycle_nxt     = '0;
                end else if (cycle_cnt == TIMEOUT_LAST) begin
                    retry_req = 1'b1;
                end else begin
                    cycle_nxt = cycle_cnt + 32'd1;
                end
            end
            RUN: begin
                if (!locked_sync) begin
                    lose_lock = 1'b1;
                end else if (!ready_in) begin
                    retry_req = 1'b1;
                end
            end
            FAULT: begin
                reset_out_nxt = '0;
                all_ready_nxt = 1'b0;
                fault_nxt     = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (lose_lock) begin
            state_nxt     = WAIT_LOCK;
            reset_out_nxt = '0;
            all_ready_nxt = 1'b0;
            stable_nxt    = '0;
            cycle_nxt     = '0;
        end else if (retry_req) begin
            reset_out_nxt = '0;
            all_ready_nxt = 1'b0;
            stable_nxt    = '0;
            cycle_nxt     = '0;
            if (retry_count < RETRY_LIMIT) begin
                retry_nxt = retry_count + 2'd1;
                state_nxt = WAIT_LOCK;
            end else begin
                state_nxt = FAULT;
                fault_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with small parameters: a per-cycle
// vector table for the nominal bring-up plus directed multi-cycle corner cases.
module tb_reset_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_WLOCK = 3'd1, S_REL = 3'd2,
                           S_WRDY = 3'd3, S_RUN = 3'd4, S_FAULT = 3'd5;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       ready_in;
    logic [2:0] reset_out;
    logic       all_ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       pll;
        logic       rdy;
        logic [2:0] exp_rst;
        logic       exp_all;
        logic [2:0] exp_st;
    } vec_t;

    vec_t vecs[19];

    reset_sequencer #(
        .SYNC_STAGES(2),
        .LOCK_STABLE_CYCLES(4),
        .STAGE_GAP_CYCLES(3),
        .READY_TIMEOUT_CYCLES(20),
        .MAX_RETRIES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pll_locked(pll_locked),
        .ready_in(ready_in),
        .reset_out(reset_out),
        .all_ready(all_ready),
        .fault(fault),
        .retry_count(retry_count),
        .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (state_dbg !== target && n < 200);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        pll_locked = 1'b0;
        ready_in   = 1'b0;
        repeat (3) tick();
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        check("rst_reset_out", 32'(reset_out), 0);
        check("rst_all_ready", 32'(all_ready), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_retry", 32'(retry_count), 0);
        reset = 1'b1;
    endtask

    initial begin
        int n;

        // Nominal bring-up, one row per clock edge after reset release.
        for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 1'b0, 3'b000, 1'b0, S_WLOCK};
        for (int i = 5; i < 8; i++) vecs[i] = '{1'b1, 1'b0, 3'b001, 1'b0, S_REL};
        for (int i = 8; i < 11; i++) vecs[i] = '{1'b1, 1'b0, 3'b011, 1'b0, S_REL};
        for (int i = 11; i < 16; i++) vecs[i] = '{1'b1, 1'b0, 3'b111, 1'b0, S_WRDY};
        for (int i = 16; i < 19; i++) vecs[i] = '{1'b1, 1'b1, 3'b111, 1'b1, S_RUN};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            pll_locked = vecs[i].pll;
            ready_in   = vecs[i].rdy;
            tick();
            check($sformatf("nom%0d_reset_out", i), 32'(reset_out), 32'(vecs[i].exp_rst));
            check($sformatf("nom%0d_all_ready", i), 32'(all_ready), 32'(vecs[i].exp_all));
            check($sformatf("nom%0d_state", i), 32'(state_dbg), 32'(vecs[i].exp_st));
            check($sformatf("nom%0d_retry", i), 32'(retry_count), 0);
        end

        // Lock loss in RUN coinciding with ready_in falling: no retry consumed.
        pll_locked = 1'b0;
        tick();
        tick();
        check("loss_pre_reset_out", 32'(reset_out), 32'h7);
        check("loss_pre_all_ready", 32'(all_ready), 1);
        ready_in = 1'b0;
        tick();
        check("loss_reset_out", 32'(reset_out), 0);
        check("loss_all_ready", 32'(all_ready), 0);
        check("loss_state", 32'(state_dbg), 32'(S_WLOCK));
        check("loss_retry", 32'(retry_count), 0);
        pll_locked = 1'b1;
        ready_in   = 1'b1;
        wait_state(S_REL, n);
        check("relock_release_latency", n, 6);
        check("relock_reset_out", 32'(reset_out), 32'h1);
        wait_state(S_WRDY, n);
        check("relock_stage_latency", n, 6);
        tick();
        check("relock_run_state", 32'(state_dbg), 32'(S_RUN));
        check("relock_all_ready", 32'(all_ready), 1);
        // ready_in falling alone in RUN consumes a retry.
        ready_in = 1'b0;
        tick();
        check("rdyfall_state", 32'(state_dbg), 32'(S_WLOCK));
        check("rdyfall_retry", 32'(retry_count), 1);
        check("rdyfall_reset_out", 32'(reset_out), 0);
        wait_state(S_REL, n);
        check("rdyfall_release_latency", n, 4);

        // One-cycle lock glitch restarts the stable window.
        do_reset();
        pll_locked = 1'b1;
        tick();
        tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_state(S_REL, n);
        check("glitch_release_latency", n, 6);

        // Ready timeout: two retries, then sticky fault.
        do_reset();
        pll_locked = 1'b1;
        wait_state(S_WRDY, n);
        check("to_first_wait_ready", n, 12);
        wait_state(S_WLOCK, n);
        check("to1_latency", n, 20);
        check("to1_retry", 32'(retry_count), 1);
        check("to1_reset_out", 32'(reset_out), 0);
        wait_state(S_WRDY, n);
        check("to1_rerelease", n, 10);
        wait_state(S_WLOCK, n);
        check("to2_latency", n, 20);
        check("to2_retry", 32'(retry_count), 2);
        wait_state(S_WRDY, n);
        check("to2_rerelease", n, 10);
        wait_state(S_FAULT, n);
        check("to3_latency", n, 20);
        check("fault_flag", 32'(fault), 1);
        check("fault_reset_out", 32'(reset_out), 0);
        check("fault_retry", 32'(retry_count), 2);
        ready_in = 1'b1;
        repeat (3) tick();
        pll_locked = 1'b0;
        repeat (4) tick();
        pll_locked = 1'b1;
        repeat (8) tick();
        check("fault_hold_state", 32'(state_dbg), 32'(S_FAULT));
        check("fault_hold_flag", 32'(fault), 1);
        check("fault_hold_reset_out", 32'(reset_out), 0);
        check("fault_hold_all_ready", 32'(all_ready), 0);

        // One-cycle reset in FAULT, then a full normal sequence.
        reset = 1'b0;
        tick();
        check("fltrst_fault", 32'(fault), 0);
        check("fltrst_retry", 32'(retry_count), 0);
        check("fltrst_state", 32'(state_dbg), 32'(S_IDLE));
        check("fltrst_reset_out", 32'(reset_out), 0);
        reset    = 1'b1;
        ready_in = 1'b0;
        wait_state(S_REL, n);
        check("fltrst_release_latency", n, 6);
        wait_state(S_WRDY, n);
        check("fltrst_stage_latency", n, 6);
        ready_in = 1'b1;
        tick();
        check("fltrst_run", 32'(state_dbg), 32'(S_RUN));
        check("fltrst_all_ready", 32'(all_ready), 1);

        // ready_in on the timeout cycle wins.
        do_reset();
        pll_locked = 1'b1;
        wait_state(S_WRDY, n);
        repeat (19) tick();
        check("pri_rdy_pre_state", 32'(state_dbg), 32'(S_WRDY));
        ready_in = 1'b1;
        tick();
        check("pri_rdy_state", 32'(state_dbg), 32'(S_RUN));
        check("pri_rdy_all_ready", 32'(all_ready), 1);
        check("pri_rdy_retry", 32'(retry_count), 0);

        // Lock loss on the timeout cycle wins, no retry.
        do_reset();
        pll_locked = 1'b1;
        wait_state(S_WRDY, n);
        repeat (17) tick();
        pll_locked = 1'b0;
        tick();
        tick();
        check("pri_loss_pre_state", 32'(state_dbg), 32'(S_WRDY));
        tick();
        check("pri_loss_state", 32'(state_dbg), 32'(S_WLOCK));
        check("pri_loss_retry", 32'(retry_count), 0);
        check("pri_loss_reset_out", 32'(reset_out), 0);

        // Lock loss together with ready_in in WAIT_READY: lock loss wins.
        do_reset();
        pll_locked = 1'b1;
        wait_state(S_WRDY, n);
        pll_locked = 1'b0;
        tick();
        tick();
        check("pri_lossrdy_pre_state", 32'(state_dbg), 32'(S_WRDY));
        ready_in = 1'b1;
        tick();
        check("pri_lossrdy_state", 32'(state_dbg), 32'(S_WLOCK));
        check("pri_lossrdy_all_ready", 32'(all_ready), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
